// File: rtl/fifo_rd_stream_adapter.sv
// Read-side adapter for async_fifo_top. It turns the FIFO's rd_en/empty/registered-dout
// interface into a valid/ready stream, using a 2-entry prefetch buffer.
//
// Handshake: a word moves downstream on every rclk edge where m_valid && m_ready.
// m_valid never depends combinationally on m_ready. Once m_valid is high it stays high,
// with m_data held stable, until that word is taken, flush is applied, or reset occurs.
module fifo_rd_stream_adapter #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 rclk,
  input  logic                 rrst_n,
  input  logic                 flush,
  input  logic                 fifo_empty,
  input  logic [WIDTH-1:0]     fifo_dout,
  output logic                 fifo_rd_en,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [WIDTH-1:0]     m_data,
  output logic [CNT_WIDTH-1:0] word_cnt,
  output logic [1:0]           dbg_occ,
  output logic                 dbg_inflight
);

  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic                 r_valid;
  logic [WIDTH-1:0]     r_buf0;
  logic [WIDTH-1:0]     r_buf1;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_pop;
  logic [1:0]           w_occ_after_pop;
  logic [1:0]           w_occ_next;
  logic [2:0]           w_level;
  logic                 w_issue;

  assign w_pop           = r_valid & m_ready;
  assign w_occ_after_pop = r_occ - {1'b0, w_pop};
  assign w_occ_next      = w_occ_after_pop + {1'b0, r_inflight};

  // A read is issued only if its word is guaranteed a free slot when it arrives.
  assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue = rrst_n & ~fifo_empty & ~flush & (w_level < 3'd2);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_valid    <= 1'b0;
      r_buf0     <= '0;
      r_buf1     <= '0;
      r_cnt      <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_pop) begin
        r_cnt <= r_cnt + CNT_WIDTH'(1);
      end
      if (flush) begin
        r_occ   <= 2'd0;
        r_valid <= 1'b0;
      end else begin
        r_occ   <= w_occ_next;
        r_valid <= (w_occ_next != 2'd0);
        if (w_pop) begin
          r_buf0 <= r_buf1;
        end
        // The arrival goes to the first slot still free after this edge's pop.
        if (r_inflight) begin
          if (w_occ_after_pop == 2'd0) begin
            r_buf0 <= fifo_dout;
          end else begin
            r_buf1 <= fifo_dout;
          end
        end
      end
    end
  end

  assign fifo_rd_en   = w_issue;
  assign m_valid      = r_valid;
  assign m_data       = r_buf0;
  assign word_cnt     = r_cnt;
  assign dbg_occ      = r_occ;
  assign dbg_inflight = r_inflight;

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter. A behavioural FIFO feeds the DUT. A queue of expected
// words is checked against every stream handshake.
module tb_fifo_rd_stream_adapter;

  localparam int W = 8;

  logic          rclk;
  logic          rrst_n;
  logic          flush;
  logic          fifo_empty;
  logic [W-1:0]  fifo_dout;
  logic          fifo_rd_en;
  logic          m_valid;
  logic          m_ready;
  logic [W-1:0]  m_data;
  logic [15:0]   word_cnt;
  logic [1:0]    dbg_occ;
  logic          dbg_inflight;

  logic          w4_rd_en;
  logic          w4_valid;
  logic [W-1:0]  w4_data;
  logic [3:0]    w4_cnt;
  logic [1:0]    w4_occ;
  logic          w4_inflight;

  fifo_rd_stream_adapter #(.WIDTH(W), .CNT_WIDTH(16)) dut (
    .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .word_cnt(word_cnt), .dbg_occ(dbg_occ), .dbg_inflight(dbg_inflight)
  );

  // Narrow-counter copy. Its inputs are identical, so it only differs in word_cnt width.
  fifo_rd_stream_adapter #(.WIDTH(W), .CNT_WIDTH(4)) dut4 (
    .rclk(rclk), .rrst_n(rrst_n), .flush(flush), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(w4_rd_en), .m_valid(w4_valid), .m_ready(m_ready),
    .m_data(w4_data), .word_cnt(w4_cnt), .dbg_occ(w4_occ), .dbg_inflight(w4_inflight)
  );

  // clock / reset
  initial begin
    rclk = 1'b0;
    forever #5 rclk = ~rclk;
  end

  typedef struct {
    int          n_words;
    int          ready_pct;
    int          gap_pct;
    logic [15:0] exp_cnt;
  } vec_t;

  logic [W-1:0] src_q[$];
  logic [W-1:0] exp_q[$];
  int           checks;
  int           errors;
  int           ready_pct;
  int           gap_pct;
  logic         gap;
  logic         rd_take;
  int           rd_viol;
  int           occ_viol;
  logic [W-1:0] next_data;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #3;
  endtask

  task automatic push_word(input logic [W-1:0] d);
    src_q.push_back(d);
    exp_q.push_back(d);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
    tick();
    tick();
  endtask

  // driver: m_ready and FIFO gaps, re-randomised each cycle
  task automatic stim_loop();
    forever begin
      @(posedge rclk);
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
      gap     = ($urandom_range(0, 99) < gap_pct);
    end
  endtask

  // behavioural FIFO: data appears the cycle after an accepted read
  task automatic fifo_model_loop();
    forever begin
      @(negedge rclk);
      rd_take = fifo_rd_en;
      if (fifo_rd_en && fifo_empty) rd_viol++;
      @(posedge rclk);
      #2;
      if (rd_take && src_q.size() > 0) fifo_dout = src_q.pop_front();
      fifo_empty = (src_q.size() == 0) || gap;
    end
  endtask

  // scoreboard: each handshake is compared at the negedge before the edge that takes it
  task automatic monitor_loop();
    logic [W-1:0] exp_d;
    forever begin
      @(negedge rclk);
      if (dbg_occ > 2'd2) occ_viol++;
      if (rrst_n && m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected actual=%0h required=none at %0t", m_data, $time);
        end else begin
          exp_d = exp_q.pop_front();
          check("sb_data", m_data, exp_d);
        end
      end
    end
  endtask

  task automatic main_seq();
    vec_t vecs[4];
    int   run;
    int   rd_pulses;
    int   n;
    vecs[0] = '{n_words: 50,   ready_pct: 100, gap_pct: 0,  exp_cnt: 16'd70};
    vecs[1] = '{n_words: 200,  ready_pct: 30,  gap_pct: 50, exp_cnt: 16'd270};
    vecs[2] = '{n_words: 1000, ready_pct: 50,  gap_pct: 30, exp_cnt: 16'd1270};
    vecs[3] = '{n_words: 100,  ready_pct: 90,  gap_pct: 80, exp_cnt: 16'd1370};

    // reset state
    tick();
    tick();
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_word_cnt", word_cnt, 0);
    check("rst_rd_en", fifo_rd_en, 0);
    rrst_n = 1'b1;
    tick();

    // back-to-back stream of 0x01..0x10
    ready_pct = 100;
    for (int i = 1; i <= 16; i++) push_word(W'(i));
    n = 0;
    do begin
      @(negedge rclk);
      n++;
    end while (!m_valid && n < 20);
    check("stream_valid_rise", m_valid, 1);
    run = 0;
    while (m_valid && run < 40) begin
      run++;
      @(negedge rclk);
    end
    check("stream_no_gap_len", run, 16);
    drain("stream", 50);
    check("stream_word_cnt", word_cnt, 16);

    // backpressure: 4 words with m_ready low
    ready_pct = 0;
    tick();
    tick();
    for (int i = 1; i <= 4; i++) push_word(W'(i));
    rd_pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge rclk);
      if (fifo_rd_en) rd_pulses++;
    end
    check("bp_rd_pulses", rd_pulses, 2);
    check("bp_valid_held", m_valid, 1);
    check("bp_data_held", m_data, 8'h01);
    check("bp_occ", dbg_occ, 2);
    ready_pct = 100;
    drain("bp", 50);
    check("bp_word_cnt", word_cnt, 20);

    // table-driven random segments
    next_data = 8'h40;
    for (int v = 0; v < 4; v++) begin
      ready_pct = vecs[v].ready_pct;
      gap_pct   = vecs[v].gap_pct;
      for (int i = 0; i < vecs[v].n_words; i++) begin
        push_word(next_data);
        next_data = next_data + 8'd7;
      end
      drain($sformatf("vec%0d", v), 20000);
      gap_pct = 0;
      check($sformatf("vec%0d_word_cnt", v), word_cnt, vecs[v].exp_cnt);
    end

    // flush with two words buffered and no read in flight
    ready_pct = 0;
    tick();
    tick();
    push_word(8'hA1);
    push_word(8'hB2);
    n = 0;
    while (!(dbg_occ == 2'd2 && !dbg_inflight) && n < 20) begin
      tick();
      n++;
    end
    check("flush_pre_occ", dbg_occ, 2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_m_valid", m_valid, 0);
    check("flush_occ", dbg_occ, 0);
    check("flush_word_cnt", word_cnt, 1370);
    exp_q.delete();
    push_word(8'hC3);
    ready_pct = 100;
    drain("flush", 50);
    check("flush_after_cnt", word_cnt, 1371);

    // asynchronous reset in the middle of a burst
    for (int i = 0; i < 8; i++) push_word(W'(8'h80 + i));
    tick();
    tick();
    tick();
    tick();
    rrst_n = 1'b0;
    #1;
    check("arst_m_valid", m_valid, 0);
    check("arst_rd_en", fifo_rd_en, 0);
    check("arst_word_cnt", word_cnt, 0);
    src_q.delete();
    exp_q.delete();
    tick();
    tick();
    rrst_n = 1'b1;
    tick();
    tick();

    // counter wrap on the 4-bit copy
    for (int i = 0; i < 17; i++) push_word(W'(8'hD0 + i));
    drain("wrap", 100);
    check("wrap_cnt16", word_cnt, 17);
    check("wrap_cnt4", w4_cnt, 1);

    check("no_rd_en_when_empty", rd_viol, 0);
    check("occ_never_over_2", occ_viol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    rrst_n     = 1'b0;
    flush      = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout  = '0;
    m_ready    = 1'b0;
    gap        = 1'b0;
    rd_take    = 1'b0;
    ready_pct  = 0;
    gap_pct    = 0;
    checks     = 0;
    errors     = 0;
    rd_viol    = 0;
    occ_viol   = 0;
    next_data  = '0;
    fork
      stim_loop();
      fifo_model_loop();
      monitor_loop();
      main_seq();
    join_any
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
